fifo_push_arb: RTL and testbench

FIFO_PUSH_ARB -- requirements
Module: fifo_push_arb

---
 rtl/fifo_push_arb.sv | 122 ++++++++++++
 tb/tb_fifo_push_arb.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_push_arb.sv
// rtl/fifo_push_arb.sv - round-robin push arbiter with per-owner burst hold
module fifo_push_arb #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  input  logic                      fifo_full_i,
  output logic                      push_o,
  output logic [DATA_W-1:0]         push_data_o,
  output logic                      busy_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = 4;

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   owner, owner_n;
  logic [IW-1:0]   rr_ptr, rr_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [IW-1:0]   base;
  logic [IW-1:0]   sel_idx;
  logic            sel_found;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_v;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
    if (x == IW'(NUM_REQ - 1)) return '0;
    return x + IW'(1);
  endfunction

  // Round-robin pick: first requester at or after the search base; on a
  // release the search starts just past the departing owner.
  always_comb begin
    int c;
    c         = 0;
    base      = (state == BURST) ? wrap_inc(owner) : rr_ptr;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      c = int'(base) + i;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!sel_found && req_i[c[IW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = c[IW-1:0];
      end
    end
  end

  // Next state and grant decision; a full FIFO freezes everything.
  always_comb begin
    state_n = state;
    owner_n = owner;
    cnt_n   = cnt;
    rr_n    = rr_ptr;
    gnt_v   = 1'b0;
    gnt_idx = '0;
    if (!fifo_full_i) begin
      if (state == BURST && req_i[owner]) begin
        gnt_v   = 1'b1;
        gnt_idx = owner;
        cnt_n   = cnt + CW'(1);
        if ((cnt + CW'(1)) == CW'(MAX_BURST)) begin
          state_n = IDLE;
          rr_n    = wrap_inc(owner);
        end
      end else if (sel_found) begin
        // Fresh owner, either from IDLE or handed over without a bubble.
        gnt_v   = 1'b1;
        gnt_idx = sel_idx;
        cnt_n   = CW'(1);
        if (MAX_BURST == 1) begin
          state_n = IDLE;
          rr_n    = wrap_inc(sel_idx);
        end else begin
          state_n = BURST;
          owner_n = sel_idx;
        end
      end else if (state == BURST) begin
        state_n = IDLE;
        cnt_n   = '0;
        rr_n    = wrap_inc(owner);
      end
    end
  end

  // Zero-latency push port; reset masks any grant immediately.
  always_comb begin
    gnt_o       = '0;
    push_data_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_v && !reset && gnt_idx == IW'(k)) begin
        gnt_o[k]    = 1'b1;
        push_data_o = req_data_i[k*DATA_W +: DATA_W];
      end
    end
    push_o = |gnt_o;
    busy_o = (state == BURST);
  end

  // Arbiter state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      owner  <= '0;
      cnt    <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_n;
      owner  <= owner_n;
      cnt    <= cnt_n;
      rr_ptr <= rr_n;
    end
  end

endmodule

// File: tb/tb_fifo_push_arb.sv
// tb/tb_fifo_push_arb.sv - scoreboard bench for fifo_push_arb
module tb_fifo_push_arb;

  logic        clk;
  logic        reset;
  logic [3:0]  req_i;
  logic [63:0] req_data_i;
  logic [3:0]  gnt_o;
  logic        fifo_full_i;
  logic        push_o;
  logic [15:0] push_data_o;
  logic        busy_o;

  fifo_push_arb #(.NUM_REQ(4), .DATA_W(16), .MAX_BURST(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req_i),
    .req_data_i  (req_data_i),
    .gnt_o       (gnt_o),
    .fifo_full_i (fifo_full_i),
    .push_o      (push_o),
    .push_data_o (push_data_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          seq      = 0;
  int          d3_ovr   = -1;
  int          mon_pushes = 0;
  logic [15:0] dk [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
  endtask

  // Monitor: every push is popped from the scoreboard; full must block pushes.
  always @(negedge clk) begin
    if (push_o) begin
      mon_pushes++;
      if (exp_q.size() == 0) begin
        chk("unexpected_push_gnt", 32'(gnt_o), 32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("grant", 32'(gnt_o), 32'(4'b0001 << mon_e.idx));
        chk("push_data", 32'(push_data_o), 32'(mon_e.data));
      end
    end
    if (fifo_full_i || reset) chk("no_push_blocked", 32'(push_o), 32'h0);
  end

  // One cycle of stimulus; exp < 0 means no grant is expected this cycle.
  task automatic step(input logic [3:0] req, input logic full, input int exp);
    logic [11:0] s;
    s = seq[11:0];
    for (int k = 0; k < 4; k++) begin
      logic [3:0] kk;
      kk = k[3:0];
      dk[k] = (d3_ovr >= 0 && k == 3) ? d3_ovr[15:0] : {kk, s};
      req_data_i[k*16 +: 16] = dk[k];
    end
    req_i       = req;
    fifo_full_i = full;
    if (exp >= 0) exp_q.push_back('{exp, dk[exp]});
    seq++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    req_i       = 4'b0000;
    fifo_full_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic end_test(input string name);
    chk(name, 32'(exp_q.size()), 32'h0);
    exp_q.delete();
  endtask

  int order [8] = '{0, 0, 0, 0, 1, 1, 1, 1};

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int fcnt;
    logic full;
    reset       = 1'b1;
    req_i       = 4'b1111;
    fifo_full_i = 1'b0;
    req_data_i  = 64'h1111_2222_3333_4444;
    #2;
    chk("rst_gnt", 32'(gnt_o), 32'h0);
    chk("rst_push", 32'(push_o), 32'h0);
    chk("rst_data", 32'(push_data_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);

    // Full round robin, 4 beats per owner.
    do_reset();
    step(4'b1111, 1'b0, 0);
    chk("busy_in_burst", 32'(busy_o), 32'h1);
    for (int i = 1; i < 16; i++) step(4'b1111, 1'b0, i / 4);
    end_test("t1_all_consumed");

    // Owner drops out early, hand-over without bubble, rr_ptr lands on 3.
    do_reset();
    step(4'b0101, 1'b0, 0);
    step(4'b0101, 1'b0, 0);
    step(4'b0100, 1'b0, 2);
    step(4'b0100, 1'b0, 2);
    step(4'b0100, 1'b0, 2);
    step(4'b0100, 1'b0, 2);
    step(4'b1101, 1'b0, 3);
    step(4'b0000, 1'b0, -1);
    chk("idle_after_release", 32'(busy_o), 32'h0);
    end_test("t2_all_consumed");

    // Full stall in the middle of a req1 burst.
    do_reset();
    step(4'b1010, 1'b0, 1);
    step(4'b1010, 1'b0, 1);
    for (int i = 0; i < 5; i++) step(4'b1010, 1'b1, -1);
    step(4'b1010, 1'b0, 1);
    step(4'b1010, 1'b0, 1);
    step(4'b1010, 1'b0, 3);
    end_test("t3_all_consumed");

    // Lone requester 3 across burst boundaries, no lost cycles.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      d3_ovr = 16'hA5A5 + i;
      step(4'b1000, 1'b0, 3);
    end
    d3_ovr = -1;
    end_test("t4_all_consumed");

    // Asynchronous reset in the middle of a req2 burst.
    do_reset();
    step(4'b0100, 1'b0, 2);
    step(4'b0100, 1'b0, 2);
    req_i = 4'b0101;
    #1;
    chk("pre_rst_push", 32'(push_o), 32'h1);
    reset = 1'b1;
    #1;
    chk("async_rst_gnt", 32'(gnt_o), 32'h0);
    chk("async_rst_push", 32'(push_o), 32'h0);
    chk("async_rst_data", 32'(push_data_o), 32'h0);
    chk("async_rst_busy", 32'(busy_o), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(4'b0101, 1'b0, 0);
    end_test("t5_all_consumed");

    // Fill an 8-deep FIFO model that never drains.
    do_reset();
    mon_pushes = 0;
    fcnt = 0;
    for (int i = 0; i < 12; i++) begin
      full = (fcnt == 8);
      step(4'b1111, full, full ? -1 : order[fcnt]);
      if (!full) fcnt++;
    end
    step(4'b0000, 1'b1, -1);
    step(4'b0000, 1'b1, -1);
    chk("fifo_push_count", 32'(mon_pushes), 32'd8);
    end_test("t6_all_consumed");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
